// File: rtl/dato_sel_sync.sv
// Per-channel capture registers feeding a registered display output.
// A channel switch is requested at any time and applied only on a frame tick.
module dato_sel_sync #(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int CH_RST = 0,
    localparam int SELW  = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  dato_in,
    input  logic [N-1:0]    dato_valid,
    input  logic [SELW-1:0] sel,
    input  logic            sel_req,
    input  logic            frame_tick,
    input  logic            hold,
    output logic [W-1:0]    dato_vga,
    output logic [SELW-1:0] canal_act,
    output logic            sel_pend,
    output logic            dato_nuevo
);

    logic [W-1:0]    cap [N];
    logic [SELW-1:0] pend;
    logic [W-1:0]    cur;
    logic            req_ok;

    assign req_ok = sel_req && (32'(sel) < N);
    assign cur    = cap[canal_act];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N; k++) cap[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (dato_valid[k]) cap[k] <= dato_in[k*W +: W];
            end
        end
    end

    // A request arriving together with the tick bypasses the pending slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend      <= SELW'(CH_RST);
            canal_act <= SELW'(CH_RST);
            sel_pend  <= 1'b0;
        end else if (req_ok && frame_tick) begin
            pend      <= sel;
            canal_act <= sel;
            sel_pend  <= 1'b0;
        end else if (req_ok) begin
            pend      <= sel;
            sel_pend  <= 1'b1;
        end else if (frame_tick && sel_pend) begin
            canal_act <= pend;
            sel_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dato_vga   <= '0;
            dato_nuevo <= 1'b0;
        end else begin
            dato_nuevo <= !hold && (cur != dato_vga);
            if (!hold) dato_vga <= cur;
        end
    end

endmodule

// File: tb/tb_dato_sel_sync.sv
// Scoreboard bench for dato_sel_sync: directed scenarios plus random traffic.
// N=5 so that out-of-range selections are expressible on the sel port.
module tb_dato_sel_sync;

    localparam int W = 8;
    localparam int N = 5;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*W-1:0]  dato_in;
    logic [N-1:0]    dato_valid;
    logic [SELW-1:0] sel;
    logic            sel_req;
    logic            frame_tick;
    logic            hold;
    logic [W-1:0]    dato_vga;
    logic [SELW-1:0] canal_act;
    logic            sel_pend;
    logic            dato_nuevo;

    dato_sel_sync #(.W(W), .N(N), .CH_RST(0)) dut (
        .clk(clk), .reset(reset), .dato_in(dato_in),
        .dato_valid(dato_valid), .sel(sel), .sel_req(sel_req),
        .frame_tick(frame_tick), .hold(hold), .dato_vga(dato_vga),
        .canal_act(canal_act), .sel_pend(sel_pend),
        .dato_nuevo(dato_nuevo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]    vga;
        logic [SELW-1:0] canal;
        logic            pend;
        logic            nuevo;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad = 0;

    logic [W-1:0]    m_cap [N];
    logic [SELW-1:0] m_pend;
    logic [SELW-1:0] m_canal;
    logic            m_pv;
    logic [W-1:0]    m_vga;
    logic            m_nuevo;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < N; k++) m_cap[k] = '0;
        m_pend = 0; m_canal = 0; m_pv = 0; m_vga = 0; m_nuevo = 0;
        q.delete();
    endtask

    task automatic idle();
        dato_valid = '0; sel_req = 0; frame_tick = 0; hold = 0; sel = 0;
    endtask

    task automatic put(int k, logic [W-1:0] v);
        dato_in[k*W +: W] = v;
        dato_valid[k] = 1'b1;
    endtask

    // Advance the model by one edge, push its prediction, then compare.
    task automatic cyc();
        exp_t e;
        logic vr;
        logic [W-1:0] nv;
        exp_t g;
        vr = sel_req && (int'(sel) < N);
        nv = hold ? m_vga : m_cap[m_canal];
        m_nuevo = !hold && (m_cap[m_canal] != m_vga);
        m_vga = nv;
        for (int k = 0; k < N; k++)
            if (dato_valid[k]) m_cap[k] = dato_in[k*W +: W];
        if (vr && frame_tick) begin
            m_canal = sel; m_pend = sel; m_pv = 0;
        end else if (vr) begin
            m_pend = sel; m_pv = 1;
        end else if (frame_tick && m_pv) begin
            m_canal = m_pend; m_pv = 0;
        end
        e.vga = m_vga; e.canal = m_canal; e.pend = m_pv; e.nuevo = m_nuevo;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        chk("sb_vga", 32'(dato_vga), 32'(g.vga));
        chk("sb_canal", 32'(canal_act), 32'(g.canal));
        chk("sb_pend", 32'(sel_pend), 32'(g.pend));
        chk("sb_nuevo", 32'(dato_nuevo), 32'(g.nuevo));
        idle();
    endtask

    initial begin
        reset = 0;
        dato_in = '0;
        idle();
        m_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dato_in = {$urandom, $urandom};
            dato_valid = N'($urandom);
            sel = SELW'($urandom);
            sel_req = 1'($urandom);
            frame_tick = 1'($urandom);
            hold = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_vga", 32'(dato_vga), 0);
            chk("rst_canal", 32'(canal_act), 0);
            chk("rst_pend", 32'(sel_pend), 0);
            chk("rst_nuevo", 32'(dato_nuevo), 0);
        end
        @(negedge clk);
        idle();
        reset = 1;

        // capture path on channel 0
        put(0, 8'h23); cyc();
        cyc();
        chk("cap_vga", 32'(dato_vga), 32'h23);
        chk("cap_pulse", 32'(dato_nuevo), 1);
        cyc();
        chk("cap_pulse_end", 32'(dato_nuevo), 0);

        // deferred switch to channel 2
        put(2, 8'hA7); cyc();
        sel = 2; sel_req = 1; cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("def_wait_canal", 32'(canal_act), 0);
            chk("def_wait_pend", 32'(sel_pend), 1);
        end
        frame_tick = 1; cyc();
        chk("def_canal", 32'(canal_act), 2);
        chk("def_pend", 32'(sel_pend), 0);
        chk("def_vga_old", 32'(dato_vga), 32'h23);
        cyc();
        chk("def_vga_new", 32'(dato_vga), 32'hA7);
        chk("def_pulse", 32'(dato_nuevo), 1);

        // out-of-range with nothing pending
        sel = 5; sel_req = 1; cyc();
        chk("oor_nopend", 32'(sel_pend), 0);
        frame_tick = 1; cyc();
        chk("tick_idle_canal", 32'(canal_act), 2);

        // overwrite and range
        sel = 1; sel_req = 1; cyc();
        sel = 3; sel_req = 1; cyc();
        sel = 5; sel_req = 1; cyc();
        sel = 7; sel_req = 1; cyc();
        chk("ovr_pend", 32'(sel_pend), 1);
        frame_tick = 1; cyc();
        chk("ovr_canal", 32'(canal_act), 3);

        // simultaneous request and tick
        sel = 1; sel_req = 1; frame_tick = 1; cyc();
        chk("sim_canal", 32'(canal_act), 1);
        chk("sim_pend", 32'(sel_pend), 0);

        // hold, then release
        sel = 0; sel_req = 1; frame_tick = 1; cyc();
        cyc(); cyc();
        hold = 1; put(0, 8'h59); cyc();
        hold = 1; cyc();
        chk("hold_vga", 32'(dato_vga), 32'h23);
        chk("hold_pulse", 32'(dato_nuevo), 0);
        cyc();
        chk("rel_vga", 32'(dato_vga), 32'h59);
        chk("rel_pulse", 32'(dato_nuevo), 1);
        put(0, 8'h59); cyc();
        cyc();
        chk("same_nopulse", 32'(dato_nuevo), 0);

        // pending request discarded by a mid-cycle reset
        sel = 2; sel_req = 1; cyc();
        chk("mid_pend", 32'(sel_pend), 1);
        #2 reset = 0;
        #1;
        chk("mid_rst_pend", 32'(sel_pend), 0);
        chk("mid_rst_vga", 32'(dato_vga), 0);
        m_reset();
        @(negedge clk);
        reset = 1;
        frame_tick = 1; cyc();
        chk("mid_canal", 32'(canal_act), 0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) dato_in[k*W +: W] = W'($urandom_range(0, 3));
            dato_valid = N'($urandom);
            sel = SELW'($urandom);
            sel_req = ($urandom_range(0, 3) == 0);
            frame_tick = ($urandom_range(0, 4) == 0);
            hold = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
